// File: rtl/midi_pkg.sv
// Shared constants, FSM state encoding and event payload for the MIDI note transmitter.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic       note_on;
    logic [6:0] note;
    logic [6:0] velocity;
  } midi_event_t;

  // Channel-voice status byte for a note event
  function automatic logic [7:0] status_byte(input logic note_on, input logic [3:0] channel);
    return {(note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), channel};
  endfunction

endpackage

// File: rtl/midi_uart_byte_tx.sv
// 8N1 UART byte transmitter; a byte is taken on entry to LOAD, either from IDLE
// or at the end of a stop bit, so consecutive bytes run without an idle gap.
module midi_uart_byte_tx
  import midi_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready_c,
  output logic       idle,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned      DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             div_done_c;
  logic             tx_nxt;
  logic             shift_c;

  assign div_done_c   = (div_cnt == DIV_LAST);
  assign byte_ready_c = (state == IDLE) || ((state == STOP) && div_done_c);

  // Next state and next serial level
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    shift_c   = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (byte_valid) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = START;
        tx_nxt    = 1'b0;
      end
      START: begin
        if (div_done_c) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
          shift_c   = 1'b1;
        end
      end
      DATA: begin
        if (div_done_c) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            tx_nxt  = shreg[0];
            shift_c = 1'b1;
          end
        end
      end
      STOP: begin
        if (div_done_c) state_nxt = byte_valid ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, divider, bit counter, shifter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      idle    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      idle  <= (state_nxt == IDLE);
      busy  <= (state_nxt != IDLE);
      // Reload on every state change and every bit boundary: no drift across bytes
      if ((state_nxt != state) || div_done_c) div_cnt <= '0;
      else                                    div_cnt <= div_cnt + DIV_W'(1);
      if (state != DATA)   bit_idx <= '0;
      else if (div_done_c) bit_idx <= bit_idx + 3'd1;
      if (byte_valid && byte_ready_c) shreg <= byte_data;
      else if (shift_c)               shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/midi_note_tx.sv
// Note event to MIDI byte stream: event latch, running-status tracking and byte sequencing.
module midi_note_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BAUD           = 31250,
  parameter int unsigned CHANNEL        = 0,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_velocity,
  output logic       midi_tx,
  output logic       busy
);

  localparam int unsigned BIT_CYCLES = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [3:0]  CHAN       = 4'(CHANNEL);

  midi_event_t ev_q;
  logic [1:0]  byte_idx;
  logic        msg_active;
  logic [7:0]  rs_byte;
  logic        rs_valid;
  logic        accept_c;
  logic        skip_c;
  logic        byte_valid_c;
  logic        byte_ready_c;
  logic        byte_fire_c;
  logic [7:0]  status_c;
  logic [7:0]  byte_data_c;

  assign accept_c     = ev_valid && ev_ready;
  assign status_c     = status_byte(ev_note_on, CHAN);
  assign skip_c       = (RUNNING_STATUS != 0) && rs_valid && (status_c == rs_byte);
  assign byte_valid_c = accept_c || msg_active;
  assign byte_fire_c  = byte_valid_c && byte_ready_c;

  // First byte comes straight from the accepted event; later bytes from the latch
  always_comb begin
    byte_data_c = 8'h00;
    if (accept_c) begin
      byte_data_c = skip_c ? {1'b0, ev_note} : status_c;
    end else begin
      case (byte_idx)
        2'd0:    byte_data_c = status_byte(ev_q.note_on, CHAN);
        2'd1:    byte_data_c = {1'b0, ev_q.note};
        default: byte_data_c = {1'b0, ev_q.velocity};
      endcase
    end
  end

  // Event latch, byte index (next byte to hand over) and running-status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q       <= '0;
      byte_idx   <= '0;
      msg_active <= 1'b0;
      rs_byte    <= '0;
      rs_valid   <= 1'b0;
    end else if (accept_c) begin
      ev_q.note_on  <= ev_note_on;
      ev_q.note     <= ev_note;
      ev_q.velocity <= ev_velocity;
      byte_idx      <= skip_c ? 2'd2 : 2'd1;
      msg_active    <= 1'b1;
      if (!skip_c) begin
        rs_byte  <= status_c;
        rs_valid <= 1'b1;
      end
    end else if (byte_fire_c) begin
      if (byte_idx == 2'd2) msg_active <= 1'b0;
      else                  byte_idx   <= byte_idx + 2'd1;
    end
  end

  midi_uart_byte_tx #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (byte_valid_c),
    .byte_data    (byte_data_c),
    .byte_ready_c (byte_ready_c),
    .idle         (ev_ready),
    .busy         (busy),
    .tx           (midi_tx)
  );

endmodule

// File: tb/tb_midi_note_tx.sv
// Directed bench for midi_note_tx: waveform-exact frame checks and byte decode.
`timescale 1ns/1ps
module tb_midi_note_tx;

  // 500 kHz / 31250 baud -> 16 cycles per bit keeps runs short
  localparam int unsigned CLK_HZ = 500_000;
  localparam int unsigned BAUD   = 31250;
  localparam int          BC     = 16;
  localparam int          LEN    = 1 + 10 * BC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_on, a_ready, a_tx, a_busy;
  logic [6:0] a_note, a_vel;
  logic       b_valid, b_on, b_ready, b_tx, b_busy;
  logic [6:0] b_note, b_vel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  midi_note_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .RUNNING_STATUS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ev_valid(a_valid), .ev_ready(a_ready),
    .ev_note_on(a_on), .ev_note(a_note), .ev_velocity(a_vel),
    .midi_tx(a_tx), .busy(a_busy)
  );

  midi_note_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(9), .RUNNING_STATUS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ev_valid(b_valid), .ev_ready(b_ready),
    .ev_note_on(b_on), .ev_note(b_note), .ev_velocity(b_vel),
    .midi_tx(b_tx), .busy(b_busy)
  );

  task automatic chk(input string tag, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? b_tx : a_tx;
  endfunction

  function automatic logic get_ready(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic on,
                       input logic [6:0] n, input logic [6:0] vel);
    if (sel) begin
      b_valid = v; b_on = on; b_note = n; b_vel = vel;
    end else begin
      a_valid = v; a_on = on; a_note = n; a_vel = vel;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge
  task automatic present(input bit sel, input logic on, input logic [6:0] n, input logic [6:0] vel);
    int w = 0;
    drive(sel, 1'b1, on, n, vel);
    while (!get_ready(sel) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!get_ready(sel)) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at negedge c=0 (first cycle after accept); checks every cycle of the message
  task automatic check_msg(input bit sel, input string name, input int nb,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] eb [3];
    logic [7:0] got [3];
    int total;
    int wave_err = 0;
    int rdy_err  = 0;
    eb[0] = b0; eb[1] = b1; eb[2] = b2;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    total = nb * LEN;
    for (int c = 0; c <= total; c++) begin
      if (c > 0) @(negedge clk);
      if (c < total) begin
        int   bi;
        int   o;
        int   slot;
        int   ph;
        logic etx;
        bi = c / LEN;
        o  = c % LEN;
        if (o == 0) begin
          etx = 1'b1;
        end else begin
          slot = (o - 1) / BC;
          ph   = (o - 1) % BC;
          if (slot == 0)      etx = 1'b0;
          else if (slot == 9) etx = 1'b1;
          else begin
            etx = eb[bi][slot-1];
            if (ph == BC / 2) got[bi][slot-1] = get_tx(sel);
          end
        end
        if (get_tx(sel) !== etx) wave_err++;
        if (get_ready(sel) !== 1'b0 || get_busy(sel) !== 1'b1) rdy_err++;
      end
    end
    chk({name, " wave_errs"}, wave_err, 0);
    chk({name, " ready_low_errs"}, rdy_err, 0);
    chk({name, " ready_rise"}, int'(get_ready(sel)), 1);
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s byte%0d", name, i), int'(got[i]), int'(eb[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    drive(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    chk("reset a tx", int'(a_tx), 1);
    chk("reset a ready", int'(a_ready), 1);
    chk("reset a busy", int'(a_busy), 0);
    chk("reset b ready", int'(b_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Status byte always sent after reset
    present(1'b0, 1'b1, 7'd60, 7'd100);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "on60", 3, 8'h90, 8'h3C, 8'h64);

    // Running status drops the repeated 0x90
    present(1'b0, 1'b1, 7'd64, 7'd90);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "rs_on64", 2, 8'h40, 8'h5A, 8'h00);

    // Status change to Note Off, then back to Note On
    present(1'b0, 1'b0, 7'd60, 7'd0);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "off60", 3, 8'h80, 8'h3C, 8'h00);
    present(1'b0, 1'b1, 7'd62, 7'd70);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "on62", 3, 8'h90, 8'h3E, 8'h46);

    // Back-pressure: second event held valid during the first message
    present(1'b0, 1'b1, 7'd65, 7'd1);
    drive(1'b0, 1'b1, 1'b0, 7'd67, 7'd127);
    check_msg(1'b0, "bp_first", 2, 8'h41, 8'h01, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "bp_second", 3, 8'h80, 8'h43, 8'h7F);

    // Reset in the middle of data bit 2 (a 0 bit of 0x90)
    present(1'b0, 1'b1, 7'd48, 7'd50);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    repeat (3 * BC + 5) @(negedge clk);
    chk("pre_reset tx", int'(a_tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("in_reset tx", int'(a_tx), 1);
    chk("in_reset ready", int'(a_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset tx", int'(a_tx), 1);
    chk("post_reset busy", int'(a_busy), 0);
    present(1'b0, 1'b1, 7'd48, 7'd50);
    drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b0, "after_rst", 3, 8'h90, 8'h30, 8'h32);

    // Channel 9, running status off: status resent every time
    present(1'b1, 1'b1, 7'd127, 7'd127);
    drive(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b1, "ch9_on127", 3, 8'h99, 8'h7F, 8'h7F);
    present(1'b1, 1'b1, 7'd64, 7'd90);
    drive(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    check_msg(1'b1, "ch9_nors", 3, 8'h99, 8'h40, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
